// File: rtl/pixel_sel.sv
// pixel_sel: 3x3 window extractor between the line-buffer read ports and the MAC array.
// Latency: 1 cycle; every rising edge loads a new window from the current inputs.
// Backpressure: none; there is no handshake, so every cycle produces a window.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   rdata0_in/rdata1_in/rdata2_in    3072-bit rows, pixel i at [3071-12i -: 12]
//   col_cnt                          centre column 0..255
//   row_sel_onehot                   line-buffer rotation state (one-hot)
//   rdata0_out/1_out/2_out           top/middle/bottom {left, centre, right}
module pixel_sel (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3071:0] rdata0_in,
  input  logic [3071:0] rdata1_in,
  input  logic [3071:0] rdata2_in,
  input  logic [7:0]    col_cnt,
  input  logic [2:0]    row_sel_onehot,
  output logic [35:0]   rdata0_out,
  output logic [35:0]   rdata1_out,
  output logic [35:0]   rdata2_out
);

  logic [35:0] w_win0, w_win1, w_win2;
  logic [35:0] w_top, w_mid, w_bot;
  logic [35:0] r_top, r_mid, r_bot;

  // Pick {left, centre, right} around column c. Neighbours past either row end
  // read as zero rather than wrapping to the opposite end of the row.
  function automatic logic [35:0] get_win(input logic [3071:0] row, input logic [7:0] c);
    int          ci;
    logic [11:0] px_l, px_c, px_r;
    ci   = int'(c);
    px_c = row[3071 - 12*ci -: 12];
    px_l = 12'h000;
    px_r = 12'h000;
    if (c != 8'd0)   px_l = row[3071 - 12*(ci - 1) -: 12];
    if (c != 8'd255) px_r = row[3071 - 12*(ci + 1) -: 12];
    return {px_l, px_c, px_r};
  endfunction

  assign w_win0 = get_win(rdata0_in, col_cnt);
  assign w_win1 = get_win(rdata1_in, col_cnt);
  assign w_win2 = get_win(rdata2_in, col_cnt);

  // Rotation state tells which buffer holds the spatially topmost row.
  // Any non-one-hot code falls back to the unrotated order.
  always_comb begin
    w_top = w_win0;
    w_mid = w_win1;
    w_bot = w_win2;
    case (row_sel_onehot)
      3'b010: begin
        w_top = w_win1;
        w_mid = w_win2;
        w_bot = w_win0;
      end
      3'b100: begin
        w_top = w_win2;
        w_mid = w_win0;
        w_bot = w_win1;
      end
      default: begin
        w_top = w_win0;
        w_mid = w_win1;
        w_bot = w_win2;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_top <= 36'h0;
      r_mid <= 36'h0;
      r_bot <= 36'h0;
    end else begin
      r_top <= w_top;
      r_mid <= w_mid;
      r_bot <= w_bot;
    end
  end

  assign rdata0_out = r_top;
  assign rdata1_out = r_mid;
  assign rdata2_out = r_bot;

endmodule

// File: tb/tb_pixel_sel.sv
module tb_pixel_sel;

  logic          clk;
  logic          rst_n;
  logic [3071:0] rdata0_in, rdata1_in, rdata2_in;
  logic [7:0]    col_cnt;
  logic [2:0]    row_sel_onehot;
  logic [35:0]   rdata0_out, rdata1_out, rdata2_out;

  int n_vec;
  int n_bad;

  pixel_sel dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdata0_in      (rdata0_in),
    .rdata1_in      (rdata1_in),
    .rdata2_in      (rdata2_in),
    .col_cnt        (col_cnt),
    .row_sel_onehot (row_sel_onehot),
    .rdata0_out     (rdata0_out),
    .rdata1_out     (rdata1_out),
    .rdata2_out     (rdata2_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  col;
    logic [2:0]  oh;
    logic [35:0] e0;
    logic [35:0] e1;
    logic [35:0] e2;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference pixel: buffer b, column c holds b*0x100 + c; out-of-row neighbours are 0.
  function automatic logic [35:0] ref_win(input int b, input int c);
    logic [11:0] l, m, r;
    m = 12'(b*256 + c);
    l = (c == 0)   ? 12'h000 : 12'(b*256 + c - 1);
    r = (c == 255) ? 12'h000 : 12'(b*256 + c + 1);
    return {l, m, r};
  endfunction

  // Which buffer lands in window position p (0 top, 1 mid, 2 bottom).
  function automatic int ref_buf(input logic [2:0] oh, input int p);
    if (oh == 3'b010) return (p + 1) % 3;
    if (oh == 3'b100) return (p + 2) % 3;
    return p;
  endfunction

  task automatic check_model(input string name, input logic [7:0] c, input logic [2:0] oh);
    check({name, "_top"}, rdata0_out, ref_win(ref_buf(oh, 0), int'(c)));
    check({name, "_mid"}, rdata1_out, ref_win(ref_buf(oh, 1), int'(c)));
    check({name, "_bot"}, rdata2_out, ref_win(ref_buf(oh, 2), int'(c)));
  endtask

  initial begin
    logic [2:0] oh;
    n_vec = 0;
    n_bad = 0;

    for (int i = 0; i < 256; i++) begin
      rdata0_in[3071 - 12*i -: 12] = 12'(i);
      rdata1_in[3071 - 12*i -: 12] = 12'(12'h100 + i);
      rdata2_in[3071 - 12*i -: 12] = 12'(12'h200 + i);
    end

    tbl[0]  = '{8'd5,   3'b001, 36'h004005006, 36'h104105106, 36'h204205206};
    tbl[1]  = '{8'd0,   3'b001, 36'h000000001, 36'h000100101, 36'h000200201};
    tbl[2]  = '{8'd255, 3'b001, 36'h0fe0ff000, 36'h1fe1ff000, 36'h2fe2ff000};
    tbl[3]  = '{8'd5,   3'b010, 36'h104105106, 36'h204205206, 36'h004005006};
    tbl[4]  = '{8'd5,   3'b100, 36'h204205206, 36'h004005006, 36'h104105106};
    tbl[5]  = '{8'd5,   3'b000, 36'h004005006, 36'h104105106, 36'h204205206};
    tbl[6]  = '{8'd5,   3'b111, 36'h004005006, 36'h104105106, 36'h204205206};
    tbl[7]  = '{8'd255, 3'b100, 36'h2fe2ff000, 36'h0fe0ff000, 36'h1fe1ff000};
    tbl[8]  = '{8'd0,   3'b010, 36'h000100101, 36'h000200201, 36'h000000001};
    tbl[9]  = '{8'd5,   3'b011, 36'h004005006, 36'h104105106, 36'h204205206};
    tbl[10] = '{8'd128, 3'b001, 36'h07f080081, 36'h17f180181, 36'h27f280281};
    tbl[11] = '{8'd254, 3'b001, 36'h0fd0fe0ff, 36'h1fd1fe1ff, 36'h2fd2fe2ff};
    tbl[12] = '{8'd1,   3'b100, 36'h200201202, 36'h000001002, 36'h100101102};
    tbl[13] = '{8'd5,   3'b110, 36'h004005006, 36'h104105106, 36'h204205206};

    // Reset state, driven from time zero before any clock edge.
    rst_n          = 1'b0;
    col_cnt        = 8'd5;
    row_sel_onehot = 3'b010;
    #1;
    check("reset_top", rdata0_out, 36'h0);
    check("reset_mid", rdata1_out, 36'h0);
    check("reset_bot", rdata2_out, 36'h0);
    @(posedge clk); #1;
    check("reset_hold", rdata0_out, 36'h0);
    rst_n = 1'b1;

    // Directed table; consecutive rows change column and rotation together.
    for (int k = 0; k < 14; k++) begin
      col_cnt        = tbl[k].col;
      row_sel_onehot = tbl[k].oh;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_top", k), rdata0_out, tbl[k].e0);
      check($sformatf("tbl%0d_mid", k), rdata1_out, tbl[k].e1);
      check($sformatf("tbl%0d_bot", k), rdata2_out, tbl[k].e2);
    end

    // Input changes between edges must not reach the outputs until the next edge.
    col_cnt        = 8'd5;
    row_sel_onehot = 3'b001;
    @(posedge clk); #1;
    col_cnt        = 8'd9;
    row_sel_onehot = 3'b100;
    #2;
    check("hold_top", rdata0_out, 36'h004005006);
    check("hold_bot", rdata2_out, 36'h204205206);
    @(posedge clk); #1;
    check("hold_next_top", rdata0_out, 36'h20820920a);
    check("hold_next_mid", rdata1_out, 36'h00800900a);

    // Sweep 0..255 and wrap back into the start, rotating at column 0.
    oh = 3'b100;
    for (int s = 0; s < 300; s++) begin
      col_cnt = 8'(s);
      if (col_cnt == 8'd0) oh = {oh[1:0], oh[2]};
      row_sel_onehot = oh;
      @(posedge clk); #1;
      check_model($sformatf("sweep%0d", s), col_cnt, oh);

      // Mid-sweep reset: clear without an edge, stay clear across an edge,
      // then the first edge after release loads the present inputs.
      if (s == 100) begin
        rst_n = 1'b0;
        #1;
        check("midrst_top", rdata0_out, 36'h0);
        check("midrst_mid", rdata1_out, 36'h0);
        check("midrst_bot", rdata2_out, 36'h0);
        @(posedge clk); #1;
        check("midrst_hold", rdata1_out, 36'h0);
        rst_n   = 1'b1;
        col_cnt = 8'd200;
        @(posedge clk); #1;
        check_model("postrst", 8'd200, oh);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
